// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute over one memory port and holds NZCV.
// Latency: Moore outputs from the state register; 3 to 5+ cycles per instruction plus memory wait states.
// Backpressure: mem_ready stalls FETCH/MEMREAD/MEMWRITE; a WAIT_LIMIT abort raises bus_err (macro ARM_CTRL_PERF_CNT_EN adds perf counters).
module arm_multicycle_controller #(
    parameter int ALU_CTL_WIDTH  = 3,
    parameter int WAIT_LIMIT     = 0,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               instr,
    input  logic [3:0]                alu_flags,
    input  logic                      mem_ready,
    output logic                      pc_write,
    output logic                      ir_write,
    output logic                      adr_src,
    output logic                      mem_write,
    output logic                      reg_write,
    output logic [1:0]                result_src,
    output logic                      alu_src_a,
    output logic [1:0]                alu_src_b,
    output logic [1:0]                imm_src,
    output logic [1:0]                reg_src,
    output logic [ALU_CTL_WIDTH-1:0]  alu_ctl,
    output logic [3:0]                flags,
    output logic                      undef,
    output logic                      bus_err,
    output logic [3:0]                state
`ifdef ARM_CTRL_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] retired,
    output logic [PERF_CNT_WIDTH-1:0] stalls
`endif
);

    // State encoding is visible on the debug port, so keep these values stable.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;

    // Wait counter only needs to reach WAIT_LIMIT; a zero limit disables the abort entirely.
    localparam bit              WAIT_ON  = (WAIT_LIMIT > 0);
    localparam int              WAIT_W   = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    state_t              cur_st;
    state_t              nxt_st;
    logic [3:0]          flags_q;
    logic [WAIT_W-1:0]   wait_cnt;

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       l_bit;
    logic       rd_pc;
    logic [15:0] instr_unused;

    assign cond  = instr[31:28];
    assign op    = instr[27:26];
    assign i_bit = instr[25];
    assign cmd   = instr[24:21];
    assign s_bit = instr[20];
    assign l_bit = instr[20];
    assign rd_pc = (instr[15:12] == 4'hF);
    assign instr_unused = {instr[19:16], instr[11:0]};

    // Data-processing command decode
    logic       dp_valid;
    logic       is_cmp;
    logic       is_arith;
    logic [2:0] dp_alu;

    // Map the data-processing command onto an ALU op; unsupported commands trap as undefined.
    always_comb begin
        dp_valid = 1'b1;
        dp_alu   = ALU_ADD;
        case (cmd)
            4'b0100: dp_alu = ALU_ADD;
            4'b0010: dp_alu = ALU_SUB;
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            4'b0001: dp_alu = ALU_EOR;
            4'b1101: dp_alu = ALU_MOV;
            4'b1010: dp_alu = ALU_SUB;
            default: dp_valid = 1'b0;
        endcase
    end

    assign is_cmp   = (cmd == 4'b1010);
    assign is_arith = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;

    // Condition check against the registered flags only, so outputs never follow alu_flags.
    logic f_n, f_z, f_c, f_v;
    logic cond_pass;
    assign {f_n, f_z, f_c, f_v} = flags_q;

    // ARM condition table; 1111 is treated as never.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = f_z;
            4'b0001: cond_pass = !f_z;
            4'b0010: cond_pass = f_c;
            4'b0011: cond_pass = !f_c;
            4'b0100: cond_pass = f_n;
            4'b0101: cond_pass = !f_n;
            4'b0110: cond_pass = f_v;
            4'b0111: cond_pass = !f_v;
            4'b1000: cond_pass = f_c && !f_z;
            4'b1001: cond_pass = !f_c || f_z;
            4'b1010: cond_pass = (f_n == f_v);
            4'b1011: cond_pass = (f_n != f_v);
            4'b1100: cond_pass = !f_z && (f_n == f_v);
            4'b1101: cond_pass = f_z || (f_n != f_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Memory states and the wait-limit abort; a completing access always beats the abort.
    logic mem_state;
    logic abort;
    assign mem_state = (cur_st == ST_FETCH) || (cur_st == ST_MEMREAD) || (cur_st == ST_MEMWRITE);
    assign abort     = WAIT_ON && mem_state && !mem_ready && (wait_cnt == WAIT_MAX);

    logic       flag_upd;
    logic [2:0] alu_sel;

    // Next-state and Moore outputs; ir/pc/mem_write additionally qualified by mem_ready.
    always_comb begin
        nxt_st     = cur_st;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_sel    = ALU_ADD;
        undef      = 1'b0;
        flag_upd   = 1'b0;
        case (cur_st)
            ST_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) begin
                    nxt_st = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (!cond_pass) begin
                    nxt_st = ST_FETCH;
                end else begin
                    case (op)
                        2'b00: begin
                            if (!dp_valid) begin
                                undef  = 1'b1;
                                nxt_st = ST_FETCH;
                            end else begin
                                nxt_st = i_bit ? ST_EXECI : ST_EXECR;
                            end
                        end
                        2'b01:   nxt_st = ST_MEMADR;
                        2'b10:   nxt_st = ST_BRANCH;
                        default: begin
                            undef  = 1'b1;
                            nxt_st = ST_FETCH;
                        end
                    endcase
                end
            end
            ST_EXECR, ST_EXECI: begin
                alu_src_b = (cur_st == ST_EXECI) ? 2'b01 : 2'b00;
                alu_sel   = dp_alu;
                flag_upd  = s_bit || is_cmp;
                nxt_st    = is_cmp ? ST_FETCH : ST_ALUWB;
            end
            ST_ALUWB: begin
                reg_write  = 1'b1;
                result_src = 2'b00;
                pc_write   = rd_pc;
                nxt_st     = ST_FETCH;
            end
            ST_MEMADR: begin
                alu_src_b = 2'b01;
                nxt_st    = l_bit ? ST_MEMREAD : ST_MEMWRITE;
            end
            ST_MEMREAD: begin
                adr_src = 1'b1;
                if (abort) begin
                    nxt_st = ST_FETCH;
                end else if (mem_ready) begin
                    nxt_st = ST_MEMWB;
                end
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                pc_write   = rd_pc;
                nxt_st     = ST_FETCH;
            end
            ST_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = !abort;
                if (abort || mem_ready) begin
                    nxt_st = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                nxt_st     = ST_FETCH;
            end
            default: nxt_st = ST_FETCH;
        endcase
        if (abort) begin
            nxt_st = ST_FETCH;
        end
    end

    assign bus_err = abort;
    assign alu_ctl = ALU_CTL_WIDTH'(alu_sel);
    assign imm_src = op;
    assign reg_src = {(op == 2'b01) && !l_bit, (op == 2'b10)};
    assign flags   = flags_q;
    assign state   = cur_st;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_st <= ST_FETCH;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // NZCV: N/Z always load on update, C/V only for arithmetic ops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else if (flag_upd) begin
            flags_q[3:2] <= alu_flags[3:2];
            if (is_arith) begin
                flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

    // Wait-state counter: clears on any state change or abort, counts stalled memory cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if ((nxt_st != cur_st) || abort) begin
            wait_cnt <= '0;
        end else if (WAIT_ON && mem_state && !mem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

`ifdef ARM_CTRL_PERF_CNT_EN
    // Retired instructions (entries into FETCH other than aborts) and stalled memory cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            retired <= '0;
            stalls  <= '0;
        end else begin
            if ((cur_st != ST_FETCH) && (nxt_st == ST_FETCH) && !abort) begin
                retired <= retired + PERF_CNT_WIDTH'(1);
            end
            if (mem_state && !mem_ready) begin
                stalls <= stalls + PERF_CNT_WIDTH'(1);
            end
        end
    end
`else
    logic perf_unused;
    assign perf_unused = (PERF_CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Testbench for arm_multicycle_controller: per-cycle expected state/controls/flags via a scoreboard.
// Latency: expectations are pushed when inputs are driven and popped on the following falling edge.
// Backpressure: mem_ready patterns exercise wait states, the wait-limit abort and completion priority.
module tb_arm_multicycle_controller;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        mem_ready;

    // Main DUT: no wait limit, 4-bit alu_ctl to observe the zero upper bit.
    logic       pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a, undef, bus_err;
    logic [1:0] result_src, alu_src_b, imm_src, reg_src;
    logic [3:0] alu_ctl, flags, state;
    logic [31:0] retired, stalls;

    // Second DUT: WAIT_LIMIT=2.
    logic       w_pc_write, w_ir_write, w_adr_src, w_mem_write, w_reg_write, w_alu_src_a, w_undef, w_bus_err;
    logic [1:0] w_result_src, w_alu_src_b, w_imm_src, w_reg_src;
    logic [2:0] w_alu_ctl;
    logic [3:0] w_flags, w_state;
    logic [31:0] w_retired, w_stalls;

    arm_multicycle_controller #(.ALU_CTL_WIDTH(4), .WAIT_LIMIT(0), .PERF_CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_write(mem_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .reg_src(reg_src), .alu_ctl(alu_ctl), .flags(flags), .undef(undef),
        .bus_err(bus_err), .state(state)
`ifdef ARM_CTRL_PERF_CNT_EN
        , .retired(retired), .stalls(stalls)
`endif
    );

    arm_multicycle_controller #(.ALU_CTL_WIDTH(3), .WAIT_LIMIT(2), .PERF_CNT_WIDTH(32)) dut_wl (
        .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
        .pc_write(w_pc_write), .ir_write(w_ir_write), .adr_src(w_adr_src), .mem_write(w_mem_write),
        .reg_write(w_reg_write), .result_src(w_result_src), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
        .imm_src(w_imm_src), .reg_src(w_reg_src), .alu_ctl(w_alu_ctl), .flags(w_flags), .undef(w_undef),
        .bus_err(w_bus_err), .state(w_state)
`ifdef ARM_CTRL_PERF_CNT_EN
        , .retired(w_retired), .stalls(w_stalls)
`endif
    );

`ifndef ARM_CTRL_PERF_CNT_EN
    assign retired = 32'd0;
    assign stalls = 32'd0;
    assign w_retired = 32'd0;
    assign w_stalls = 32'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector: {pcw, irw, adr, mw, rw, result_src, asa, asb, alu_ctl[3:0], undef, bus_err}
    logic [15:0] obs_ctl, w_obs_ctl;
    assign obs_ctl = {pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
                      alu_src_a, alu_src_b, alu_ctl, undef, bus_err};
    assign w_obs_ctl = {w_pc_write, w_ir_write, w_adr_src, w_mem_write, w_reg_write, w_result_src,
                        w_alu_src_a, w_alu_src_b, {1'b0, w_alu_ctl}, w_undef, w_bus_err};

    typedef struct packed {
        logic [15:0] id;
        logic        wl;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [3:0]  fl;
        logic [3:0]  isr;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   id_cnt = 0;
    logic cur_wl;
    logic [3:0] cur_isr;
    logic [3:0] efl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] pk(input logic pcw, input logic irw, input logic adr, input logic mw,
                                       input logic rw, input logic [1:0] rs, input logic asa,
                                       input logic [1:0] asb, input logic [3:0] alu,
                                       input logic und, input logic be);
        return {pcw, irw, adr, mw, rw, rs, asa, asb, alu, und, be};
    endfunction

    function automatic logic [15:0] c_fetch(input logic mr);
        return pk(mr, mr, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 4'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] c_fetch_abort();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 4'd0, 1'b0, 1'b1);
    endfunction
    function automatic logic [15:0] c_dec(input logic und);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 4'd0, und, 1'b0);
    endfunction
    function automatic logic [15:0] c_exec(input logic imm, input logic [3:0] alu);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, imm ? 2'b01 : 2'b00, alu, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] c_aluwb(input logic pcw);
        return pk(pcw, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] c_memadr();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] c_memread();
        return pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] c_memwb(input logic pcw);
        return pk(pcw, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] c_memwrite(input logic ab);
        return pk(1'b0, 1'b0, 1'b1, ~ab, 1'b0, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0, ab);
    endfunction
    function automatic logic [15:0] c_branch();
        return pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 4'd0, 1'b0, 1'b0);
    endfunction

    // Drive one cycle of inputs and queue what the selected DUT must show in that cycle.
    task automatic cyc(input logic [3:0] st, input logic [15:0] ctl, input logic mr, input logic [3:0] af);
        exp_t e;
        mem_ready = mr;
        alu_flags = af;
        e.id  = 16'(id_cnt);
        e.wl  = cur_wl;
        e.st  = st;
        e.ctl = ctl;
        e.fl  = efl;
        e.isr = cur_isr;
        sb.push_back(e);
        id_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Cycle outside EXEC: alu_flags is randomised since it must not influence anything there.
    task automatic c(input logic [3:0] st, input logic [15:0] ctl, input logic mr);
        cyc(st, ctl, mr, 4'($urandom));
    endtask

    task automatic load(input logic [31:0] i, input logic [3:0] isr);
        instr   = i;
        cur_isr = isr;
    endtask

    task automatic run_dp(input logic [31:0] i, input logic imm, input logic [3:0] alu,
                          input logic [3:0] af, input logic [3:0] new_fl, input logic wb, input logic pcw);
        load(i, 4'b0000);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b0), 1'b1);
        cyc(imm ? S_EXECI : S_EXECR, c_exec(imm, alu), 1'b1, af);
        efl = new_fl;
        if (wb) c(S_ALUWB, c_aluwb(pcw), 1'b1);
    endtask

    // Monitor: pop one expectation per cycle on the falling edge and compare.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.wl) begin
                check($sformatf("c%0d.state", e.id), 32'(w_state), 32'(e.st));
                check($sformatf("c%0d.ctl", e.id), 32'(w_obs_ctl), 32'(e.ctl));
                check($sformatf("c%0d.flags", e.id), 32'(w_flags), 32'(e.fl));
                check($sformatf("c%0d.imm_reg_src", e.id), 32'({w_imm_src, w_reg_src}), 32'(e.isr));
            end else begin
                check($sformatf("c%0d.state", e.id), 32'(state), 32'(e.st));
                check($sformatf("c%0d.ctl", e.id), 32'(obs_ctl), 32'(e.ctl));
                check($sformatf("c%0d.flags", e.id), 32'(flags), 32'(e.fl));
                check($sformatf("c%0d.imm_reg_src", e.id), 32'({imm_src, reg_src}), 32'(e.isr));
            end
        end
    end

    initial begin
        reset = 1'b0;
        instr = 32'hE2821005;
        alu_flags = 4'd0;
        mem_ready = 1'b1;
        cur_wl = 1'b0;
        cur_isr = 4'b0000;
        efl = 4'b0000;
        @(posedge clk);
        #1;
        // Reset state, still held in reset
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        reset = 1'b1;

        // ADD R1,R2,#5 with alu_flags all ones: no S, flags hold
        run_dp(32'hE2821005, 1'b1, 4'd0, 4'b1111, 4'b0000, 1'b1, 1'b0);
        // SUBS sets Z
        run_dp(32'hE2511001, 1'b1, 4'd1, 4'b0100, 4'b0100, 1'b1, 1'b0);
        // ADDEQ passes
        run_dp(32'h02821005, 1'b1, 4'd0, 4'b0000, 4'b0100, 1'b1, 1'b0);
        // ADDS loads all four
        run_dp(32'hE2911005, 1'b1, 4'd0, 4'b0011, 4'b0011, 1'b1, 1'b0);
        // ANDS loads N,Z only; C,V hold at 1
        run_dp(32'hE211100F, 1'b1, 4'd2, 4'b1100, 4'b1111, 1'b1, 1'b0);
        // SUB register form, no S
        run_dp(32'hE0413002, 1'b0, 4'd1, 4'b0000, 4'b1111, 1'b1, 1'b0);
        // CMP clears flags, no writeback
        run_dp(32'hE3510000, 1'b1, 4'd1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // ADDEQ now fails; cond 1111 also fails
        load(32'h02821005, 4'b0000);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b0), 1'b1);
        load(32'hF2821005, 4'b0000);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b0), 1'b1);
        // MOV PC,#8: writeback also writes PC
        run_dp(32'hE3A0F008, 1'b1, 4'd5, 4'b0000, 4'b0000, 1'b1, 1'b1);
        // EOR register, ORR immediate
        run_dp(32'hE0213002, 1'b0, 4'd4, 4'b1111, 4'b0000, 1'b1, 1'b0);
        run_dp(32'hE3813002, 1'b1, 4'd3, 4'b1111, 4'b0000, 1'b1, 1'b0);
        // Unsupported command (RSB) and op 11 trap as undefined
        load(32'hE2611000, 4'b0000);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b1), 1'b1);
        load(32'hEC000000, 4'b1100);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b1), 1'b1);
        // Branch
        load(32'hEA000002, 4'b1001);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b0), 1'b1);
        c(S_BRANCH, c_branch(), 1'b1);
        // LDR with three wait states in MEMREAD
        load(32'hE5921004, 4'b0100);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b0), 1'b1);
        c(S_MEMADR, c_memadr(), 1'b1);
        for (int k = 0; k < 3; k++) c(S_MEMREAD, c_memread(), 1'b0);
        c(S_MEMREAD, c_memread(), 1'b1);
        c(S_MEMWB, c_memwb(1'b0), 1'b1);
        // LDR PC with fetch wait states
        load(32'hE591F004, 4'b0100);
        c(S_FETCH, c_fetch(1'b0), 1'b0);
        c(S_FETCH, c_fetch(1'b0), 1'b0);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b0), 1'b1);
        c(S_MEMADR, c_memadr(), 1'b1);
        c(S_MEMREAD, c_memread(), 1'b1);
        c(S_MEMWB, c_memwb(1'b1), 1'b1);
        // STR with one wait state; mem_write held through completion
        load(32'hE5821004, 4'b0110);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b0), 1'b1);
        c(S_MEMADR, c_memadr(), 1'b1);
        c(S_MEMWRITE, c_memwrite(1'b0), 1'b0);
        c(S_MEMWRITE, c_memwrite(1'b0), 1'b1);

        // Reset mid-MEMWRITE with nonzero flags
        run_dp(32'hE2911005, 1'b1, 4'd0, 4'b0011, 4'b0011, 1'b1, 1'b0);
        load(32'hE5821004, 4'b0110);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b0), 1'b1);
        c(S_MEMADR, c_memadr(), 1'b1);
        reset = 1'b0;
        c(S_MEMWRITE, c_memwrite(1'b0), 1'b0);
        reset = 1'b1;
        efl = 4'b0000;
`ifdef ARM_CTRL_PERF_CNT_EN
        check("perf.retired_rst", retired, 32'd0);
        check("perf.stalls_rst", stalls, 32'd0);
`endif
        c(S_FETCH, c_fetch(1'b0), 1'b0);
        run_dp(32'hE2821005, 1'b1, 4'd0, 4'b0000, 4'b0000, 1'b1, 1'b0);
`ifdef ARM_CTRL_PERF_CNT_EN
        check("perf.retired", retired, 32'd1);
        check("perf.stalls", stalls, 32'd1);
`endif

        // Wait-limit DUT: resynchronise, then STR with mem_ready stuck low
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cur_wl = 1'b1;
        efl = 4'b0000;
        load(32'hE5821004, 4'b0110);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b0), 1'b1);
        c(S_MEMADR, c_memadr(), 1'b1);
        c(S_MEMWRITE, c_memwrite(1'b0), 1'b0);
        c(S_MEMWRITE, c_memwrite(1'b0), 1'b0);
        c(S_MEMWRITE, c_memwrite(1'b1), 1'b0);
        // Stuck fetch also aborts after two low cycles
        c(S_FETCH, c_fetch(1'b0), 1'b0);
        c(S_FETCH, c_fetch(1'b0), 1'b0);
        c(S_FETCH, c_fetch_abort(), 1'b0);
        // mem_ready arriving exactly at the limit completes instead of aborting
        c(S_FETCH, c_fetch(1'b0), 1'b0);
        c(S_FETCH, c_fetch(1'b0), 1'b0);
        c(S_FETCH, c_fetch(1'b1), 1'b1);
        c(S_DECODE, c_dec(1'b0), 1'b1);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
